// File: rtl/uart_rx_fifo_mm_pkg.sv
// Shared UART MMIO definitions: word addresses, status bit positions and the
// status word packer used by the receive buffer (and later the TX side).
package uart_rx_fifo_mm_pkg;

    localparam logic [31:0] UART_ADDR_BASE   = 32'd65537;
    localparam logic [31:0] UART_ADDR_STATUS = UART_ADDR_BASE + 32'd4;
    localparam logic [31:0] UART_ADDR_DATA   = UART_ADDR_BASE + 32'd5;
    localparam logic [31:0] UART_ADDR_CTRL   = UART_ADDR_BASE + 32'd6;

    localparam int STAT_NEMPTY    = 0;
    localparam int STAT_OVF       = 1;
    localparam int STAT_FULL      = 2;
    localparam int STAT_COUNT_LSB = 8;
    localparam int STAT_COUNT_MSB = 15;

    function automatic logic [31:0] pack_status(
        input logic [7:0] count,
        input logic       full,
        input logic       ovf,
        input logic       nempty
    );
        logic [31:0] w;
        w = '0;
        w[STAT_COUNT_MSB:STAT_COUNT_LSB] = count;
        w[STAT_FULL]   = full;
        w[STAT_OVF]    = ovf;
        w[STAT_NEMPTY] = nempty;
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_mm_fifo_core.sv
// Synchronous FIFO with simultaneous push/pop; a push on a full FIFO is only
// accepted when a pop frees the head slot in the same cycle.
module uart_fifo_core #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [AW:0]   count,
    output logic [AW:0]   count_next,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          wr_en, rd_en;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign rd_en = pop & ~empty;
    // When full, the slot being written is the head being popped this edge.
    assign wr_en = push & (~full | rd_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= din;
    end

    assign dout       = mem_q[rd_ptr_q];
    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/uart_rx_fifo_mm.sv
// UART receive buffer: edge-detects incoming bytes into a FIFO and exposes
// status/data/control words on the port-B MMIO bus with a level interrupt.
module uart_rx_fifo_mm
    import uart_rx_fifo_mm_pkg::*;
#(
    parameter int          DEPTH       = 16,
    parameter int          AW          = 4,
    parameter int          THRESH      = 1,
    parameter logic [31:0] ADDR_STATUS = UART_ADDR_STATUS,
    parameter logic [31:0] ADDR_DATA   = UART_ADDR_DATA,
    parameter logic [31:0] ADDR_CTRL   = UART_ADDR_CTRL
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  uart_din,
    input  logic        uart_valid,
    output logic        irq,
    output logic [31:0] data_b,
    output logic        strobe_b,
    input  logic [31:0] addr_b,
    input  logic [31:0] data_b_in,
    input  logic [31:0] data_b_we
);

    localparam logic [AW:0] THRESH_C = THRESH[AW:0];

    logic        valid_q, valid_d;
    logic        hit_q, hit_d;
    logic        armed_q, armed_d;
    logic        overflow_q, overflow_d;
    logic        irq_en_q, irq_en_d;
    logic        irq_q, irq_d;

    logic        sel_status, sel_data, sel_ctrl, wr_any;
    logic        push, pop, rd_hit, ovf_set, ovf_clr;
    logic [7:0]  fifo_dout;
    logic [AW:0] fifo_count, count_next;
    logic        fifo_full, fifo_empty;
    logic        unused_wdata;

    assign unused_wdata = ^data_b_in[31:2];

    assign sel_status = (addr_b == ADDR_STATUS);
    assign sel_data   = (addr_b == ADDR_DATA);
    assign sel_ctrl   = (addr_b == ADDR_CTRL);
    assign wr_any     = |data_b_we;
    assign strobe_b   = sel_status | sel_data | sel_ctrl;

    // uart_valid is a level with no ready: a byte is taken on its rising edge
    // only, and one arriving on a full FIFO without a same-cycle pop is dropped
    // and recorded as overflow. armed_q keeps a level already high at reset
    // release from counting as an edge.
    assign push   = uart_valid & ~valid_q & armed_q;
    assign rd_hit = sel_data & ~wr_any;
    assign pop    = rd_hit & ~hit_q & ~fifo_empty;

    assign ovf_set = push & fifo_full & ~pop;
    assign ovf_clr = wr_any & sel_status & data_b_in[STAT_OVF];

    uart_fifo_core #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (8)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .din        (uart_din),
        .dout       (fifo_dout),
        .count      (fifo_count),
        .count_next (count_next),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_comb begin
        valid_d    = uart_valid;
        hit_d      = rd_hit;
        armed_d    = 1'b1;
        overflow_d = ovf_set | (overflow_q & ~ovf_clr);
        irq_en_d   = irq_en_q;
        if (wr_any & sel_ctrl) irq_en_d = data_b_in[0];
        irq_d      = irq_en_q & ((count_next >= THRESH_C) | overflow_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= 1'b0;
            hit_q      <= 1'b0;
            armed_q    <= 1'b0;
            overflow_q <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            hit_q      <= hit_d;
            armed_q    <= armed_d;
            overflow_q <= overflow_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        data_b = '0;
        if (sel_status) begin
            data_b = pack_status(8'(fifo_count), fifo_full, overflow_q, ~fifo_empty);
        end else if (sel_data) begin
            data_b = fifo_empty ? 32'h0 : {24'h0, fifo_dout};
        end else if (sel_ctrl) begin
            data_b = {31'h0, irq_en_q};
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo_mm.sv
// Self-checking bench for uart_rx_fifo_mm: byte scoreboard fed on push,
// popped and compared on every data-word read.
module tb_uart_rx_fifo_mm;

  localparam logic [31:0] A_STATUS = 32'd65541;
  localparam logic [31:0] A_DATA   = 32'd65542;
  localparam logic [31:0] A_CTRL   = 32'd65543;

  logic        clk;
  logic        rst;
  logic [7:0]  uart_din;
  logic        uart_valid;
  logic        irq;
  logic [31:0] data_b;
  logic        strobe_b;
  logic [31:0] addr_b;
  logic [31:0] data_b_in;
  logic [31:0] data_b_we;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  uart_rx_fifo_mm dut (
    .clk        (clk),
    .rst        (rst),
    .uart_din   (uart_din),
    .uart_valid (uart_valid),
    .irq        (irq),
    .data_b     (data_b),
    .strobe_b   (strobe_b),
    .addr_b     (addr_b),
    .data_b_in  (data_b_in),
    .data_b_we  (data_b_we)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no summary, required completion");
    $fatal(1, "timeout");
  end

  task automatic drive_idle();
    uart_valid = 1'b0;
    uart_din   = 8'h00;
    addr_b     = 32'h0;
    data_b_in  = 32'h0;
    data_b_we  = 32'h0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    drive_idle();
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // driver tasks
  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    uart_din   = b;
    uart_valid = 1'b1;
    @(negedge clk);
    uart_valid = 1'b0;
  endtask

  task automatic mmio_read(input logic [31:0] a, input int hold, output logic [31:0] d);
    @(negedge clk);
    addr_b    = a;
    data_b_we = 32'h0;
    #1;
    d = data_b;
    repeat (hold) @(negedge clk);
    addr_b = 32'h0;
  endtask

  task automatic mmio_write(input logic [31:0] a, input logic [31:0] v, input logic [31:0] we);
    @(negedge clk);
    addr_b    = a;
    data_b_in = v;
    data_b_we = we;
    @(negedge clk);
    data_b_we = 32'h0;
    data_b_in = 32'h0;
    addr_b    = 32'h0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b0;
    drive_idle();
    exp_q.delete();
    uart_valid = 1'b1;
    uart_din   = 8'hEE;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b required 0", irq); end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    uart_valid = 1'b0;
    repeat (2) @(negedge clk);
    mmio_read(A_STATUS, 0, d);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL reset_status: got %h required %h", d, 32'h0); end
    mmio_read(A_DATA, 1, d);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h required %h", d, 32'h0); end
    mmio_read(A_CTRL, 0, d);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL reset_ctrl: got %h required %h", d, 32'h0); end
    mmio_read(A_STATUS, 0, d);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL empty_read_status: got %h required %h", d, 32'h0); end
    @(negedge clk);
    addr_b = A_STATUS; #1;
    n_cmp++;
    if (strobe_b !== 1'b1) begin n_err++; $display("FAIL strobe_status: got %b required 1", strobe_b); end
    addr_b = A_CTRL; #1;
    n_cmp++;
    if (strobe_b !== 1'b1) begin n_err++; $display("FAIL strobe_ctrl: got %b required 1", strobe_b); end
    addr_b = 32'd65540; #1;
    n_cmp++;
    if (strobe_b !== 1'b0 || data_b !== 32'h0) begin
      n_err++; $display("FAIL strobe_below: got %b/%h required 0/0", strobe_b, data_b);
    end
    addr_b = 32'd65544; #1;
    n_cmp++;
    if (strobe_b !== 1'b0 || data_b !== 32'h0) begin
      n_err++; $display("FAIL strobe_above: got %b/%h required 0/0", strobe_b, data_b);
    end
    addr_b = 32'h0;
  endtask

  task automatic test_basic_pop();
    logic [31:0] d;
    logic [7:0]  e;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      push_byte(8'h41 + 8'(i));
      exp_q.push_back(8'h41 + 8'(i));
    end
    mmio_read(A_STATUS, 0, d);
    n_cmp++;
    if (d !== 32'h0000_0301) begin n_err++; $display("FAIL basic_status3: got %h required %h", d, 32'h0000_0301); end
    for (int i = 0; i < 3; i++) begin
      mmio_read(A_DATA, 3, d);
      e = exp_q.pop_front();
      n_cmp++;
      if (d !== {24'h0, e}) begin n_err++; $display("FAIL basic_pop%0d: got %h required %h", i, d, {24'h0, e}); end
    end
    mmio_read(A_STATUS, 0, d);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL basic_status0: got %h required %h", d, 32'h0); end
  endtask

  task automatic test_held_valid();
    logic [31:0] d;
    logic [7:0]  e;
    apply_reset();
    @(negedge clk);
    uart_din   = 8'h55;
    uart_valid = 1'b1;
    exp_q.push_back(8'h55);
    repeat (10) @(negedge clk);
    uart_valid = 1'b0;
    mmio_read(A_STATUS, 0, d);
    n_cmp++;
    if (d !== 32'h0000_0101) begin n_err++; $display("FAIL held_status: got %h required %h", d, 32'h0000_0101); end
    mmio_read(A_DATA, 2, d);
    e = exp_q.pop_front();
    n_cmp++;
    if (d !== {24'h0, e}) begin n_err++; $display("FAIL held_pop: got %h required %h", d, {24'h0, e}); end
    mmio_read(A_STATUS, 0, d);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL held_drained: got %h required %h", d, 32'h0); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic [7:0]  b;
    logic [7:0]  e;
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom_range(0, 255));
      push_byte(b);
      if (i < 16) exp_q.push_back(b);
    end
    mmio_read(A_STATUS, 0, d);
    n_cmp++;
    if (d !== 32'h0000_1007) begin n_err++; $display("FAIL ovf_status: got %h required %h", d, 32'h0000_1007); end
    mmio_write(A_DATA, 32'hFFFF_FFFF, 32'h8000_0000);
    mmio_read(A_STATUS, 0, d);
    n_cmp++;
    if (d !== 32'h0000_1007) begin n_err++; $display("FAIL data_write_ignored: got %h required %h", d, 32'h0000_1007); end
    mmio_write(A_STATUS, 32'h2, 32'h0000_0100);
    mmio_read(A_STATUS, 0, d);
    n_cmp++;
    if (d !== 32'h0000_1005) begin n_err++; $display("FAIL ovf_clear_full: got %h required %h", d, 32'h0000_1005); end
    @(negedge clk);
    uart_din   = 8'hA5;
    uart_valid = 1'b1;
    addr_b     = A_STATUS;
    data_b_in  = 32'h2;
    data_b_we  = 32'h1;
    @(negedge clk);
    uart_valid = 1'b0;
    data_b_we  = 32'h0;
    data_b_in  = 32'h0;
    addr_b     = 32'h0;
    mmio_read(A_STATUS, 0, d);
    n_cmp++;
    if (d !== 32'h0000_1007) begin n_err++; $display("FAIL ovf_set_wins: got %h required %h", d, 32'h0000_1007); end
    for (int i = 0; i < 16; i++) begin
      mmio_read(A_DATA, $urandom_range(1, 3), d);
      e = exp_q.pop_front();
      n_cmp++;
      if (d !== {24'h0, e}) begin n_err++; $display("FAIL ovf_pop%0d: got %h required %h", i, d, {24'h0, e}); end
    end
    mmio_read(A_STATUS, 0, d);
    n_cmp++;
    if (d !== 32'h0000_0002) begin n_err++; $display("FAIL ovf_sticky_empty: got %h required %h", d, 32'h0000_0002); end
    mmio_write(A_STATUS, 32'h2, 32'h1);
    mmio_read(A_STATUS, 0, d);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL ovf_cleared: got %h required %h", d, 32'h0); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] d;
    logic [7:0]  b;
    logic [7:0]  e;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(0, 255));
      push_byte(b);
      exp_q.push_back(b);
    end
    @(negedge clk);
    uart_din   = 8'hC3;
    uart_valid = 1'b1;
    addr_b     = A_DATA;
    data_b_we  = 32'h0;
    #1;
    d = data_b;
    e = exp_q.pop_front();
    exp_q.push_back(8'hC3);
    n_cmp++;
    if (d !== {24'h0, e}) begin n_err++; $display("FAIL fpp_old_head: got %h required %h", d, {24'h0, e}); end
    @(negedge clk);
    uart_valid = 1'b0;
    repeat (2) @(negedge clk);
    addr_b = 32'h0;
    mmio_read(A_STATUS, 0, d);
    n_cmp++;
    if (d !== 32'h0000_1005) begin n_err++; $display("FAIL fpp_status: got %h required %h", d, 32'h0000_1005); end
    for (int i = 0; i < 16; i++) begin
      mmio_read(A_DATA, 1, d);
      e = exp_q.pop_front();
      n_cmp++;
      if (d !== {24'h0, e}) begin n_err++; $display("FAIL fpp_pop%0d: got %h required %h", i, d, {24'h0, e}); end
    end
    mmio_read(A_STATUS, 0, d);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL fpp_drained: got %h required %h", d, 32'h0); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    logic [7:0]  e;
    apply_reset();
    mmio_write(A_CTRL, 32'h1, 32'h1);
    mmio_read(A_CTRL, 0, d);
    n_cmp++;
    if (d !== 32'h1) begin n_err++; $display("FAIL irq_ctrl_rd: got %h required %h", d, 32'h1); end
    @(negedge clk);
    uart_din   = 8'h5A;
    uart_valid = 1'b1;
    exp_q.push_back(8'h5A);
    #1;
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL irq_before_push: got %b required 0", irq); end
    @(negedge clk);
    uart_valid = 1'b0;
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL irq_after_push: got %b required 1", irq); end
    @(negedge clk);
    addr_b = A_DATA;
    #1;
    d = data_b;
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL irq_before_pop: got %b required 1", irq); end
    @(negedge clk);
    addr_b = 32'h0;
    e = exp_q.pop_front();
    n_cmp++;
    if (d !== {24'h0, e}) begin n_err++; $display("FAIL irq_pop_data: got %h required %h", d, {24'h0, e}); end
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL irq_after_pop: got %b required 0", irq); end
    mmio_write(A_CTRL, 32'h0, 32'h1);
    for (int i = 0; i < 17; i++) push_byte(8'($urandom_range(0, 255)));
    mmio_read(A_STATUS, 0, d);
    n_cmp++;
    if (d !== 32'h0000_1007 || irq !== 1'b0) begin
      n_err++; $display("FAIL irq_masked: got %h/%b required %h/0", d, irq, 32'h0000_1007);
    end
    mmio_write(A_CTRL, 32'h1, 32'h1);
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL irq_unmasked: got %b required 1", irq); end
    mmio_write(A_CTRL, 32'h0, 32'h1);
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL irq_remasked: got %b required 0", irq); end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] d;
    logic [7:0]  e;
    apply_reset();
    mmio_write(A_CTRL, 32'h1, 32'h1);
    for (int i = 0; i < 5; i++) begin
      push_byte(8'h60 + 8'(i));
      exp_q.push_back(8'h60 + 8'(i));
    end
    mmio_read(A_STATUS, 0, d);
    n_cmp++;
    if (d !== 32'h0000_0501 || irq !== 1'b1) begin
      n_err++; $display("FAIL mid_before: got %h/%b required %h/1", d, irq, 32'h0000_0501);
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL mid_irq: got %b required 0", irq); end
    addr_b = A_STATUS; #1;
    n_cmp++;
    if (data_b !== 32'h0) begin n_err++; $display("FAIL mid_status: got %h required %h", data_b, 32'h0); end
    addr_b = A_DATA; #1;
    n_cmp++;
    if (data_b !== 32'h0) begin n_err++; $display("FAIL mid_data: got %h required %h", data_b, 32'h0); end
    addr_b = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    mmio_read(A_DATA, 1, d);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL mid_data_after: got %h required %h", d, 32'h0); end
    mmio_read(A_CTRL, 0, d);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL mid_ctrl_after: got %h required %h", d, 32'h0); end
    push_byte(8'h99);
    exp_q.push_back(8'h99);
    mmio_read(A_STATUS, 0, d);
    n_cmp++;
    if (d !== 32'h0000_0101) begin n_err++; $display("FAIL mid_restart_status: got %h required %h", d, 32'h0000_0101); end
    mmio_read(A_DATA, 1, d);
    e = exp_q.pop_front();
    n_cmp++;
    if (d !== {24'h0, e}) begin n_err++; $display("FAIL mid_restart_pop: got %h required %h", d, {24'h0, e}); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [7:0]  b;
    logic [7:0]  e;
    apply_reset();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 11; i++) begin
        b = 8'($urandom_range(0, 255));
        push_byte(b);
        exp_q.push_back(b);
      end
      while (exp_q.size() > 0) begin
        mmio_read(A_DATA, 1, d);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== {24'h0, e}) begin n_err++; $display("FAIL b2b_r%0d_pop: got %h required %h", r, d, {24'h0, e}); end
      end
    end
    mmio_read(A_STATUS, 0, d);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL b2b_drained: got %h required %h", d, 32'h0); end
  endtask

  initial begin
    rst = 1'b0;
    drive_idle();
    test_reset();
    test_basic_pop();
    test_held_valid();
    test_overflow();
    test_full_push_pop();
    test_irq();
    test_reset_midstream();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
